// File: rtl/bin_to_oh_seq.sv
// Sequenced binary-to-one-hot selector: all-zero guard, then a timed dwell on the new select.
// Define BIN_TO_OH_RANGE_CHECK_EN to reject indices >= WIDTH_OUT with a one-cycle err pulse.
module bin_to_oh_seq #(
   parameter int WIDTH_OUT    = 8,
   parameter int WIDTH_IN     = $clog2(WIDTH_OUT),
   parameter int GUARD_CYCLES = 2,
   parameter int DWELL_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH_IN-1:0]  in_bin,
   output logic [WIDTH_OUT-1:0] oh,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int MAX_CYCLES = (GUARD_CYCLES > DWELL_CYCLES) ? GUARD_CYCLES : DWELL_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      GUARD,
      DWELL
   } state_t;

   state_t               state, state_d;
   logic [CNT_W-1:0]     cnt, cnt_d;
   logic [WIDTH_IN-1:0]  idx, idx_d;
   logic [WIDTH_OUT-1:0] oh_d;
   logic                 busy_d, done_d, err_d, ready_d;
   logic                 accept, out_of_range;

   // An index past the top bit decodes to all zeros.
   function automatic logic [WIDTH_OUT-1:0] to_onehot(input logic [WIDTH_IN-1:0] b);
      logic [WIDTH_OUT-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH_OUT; i++) begin
         if (32'(b) == i) r[i] = 1'b1;
      end
      return r;
   endfunction

   assign accept = in_valid && in_ready && (state == IDLE);

`ifdef BIN_TO_OH_RANGE_CHECK_EN
   assign out_of_range = (32'(in_bin) >= 32'(WIDTH_OUT));
`else
   assign out_of_range = 1'b0;
`endif

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      idx_d   = idx;
      oh_d    = oh;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (out_of_range) begin
                  err_d = 1'b1;
               end else begin
                  state_d = GUARD;
                  cnt_d   = CNT_W'(GUARD_CYCLES - 1);
                  idx_d   = in_bin;
                  oh_d    = '0;
               end
            end
         end
         GUARD: begin
            if (cnt == '0) begin
               state_d = DWELL;
               cnt_d   = CNT_W'(DWELL_CYCLES - 1);
               oh_d    = to_onehot(idx);
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         DWELL: begin
            if (cnt == '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      // Flags are computed from the next state so they line up with it once registered.
      busy_d  = (state_d != IDLE);
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         idx      <= '0;
         oh       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         in_ready <= 1'b0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         idx      <= idx_d;
         oh       <= oh_d;
         busy     <= busy_d;
         done     <= done_d;
         err      <= err_d;
         in_ready <= ready_d;
      end
   end

endmodule

// File: tb/tb_bin_to_oh_seq.sv
// Scoreboard bench for bin_to_oh_seq: default instance, a 6-output range instance
// and a minimal-timing instance for the one-hot invariant.
module tb_bin_to_oh_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checkCount = 0;
   int passCount  = 0;

   logic       rstA, validA, readyA, busyA, doneA, errA;
   logic [2:0] binA;
   logic [7:0] ohA;

   logic       rstR, validR, readyR, busyR, doneR, errR;
   logic [2:0] binR;
   logic [5:0] ohR;

   logic       rstF, validF, readyF, busyF, doneF, errF;
   logic [2:0] binF;
   logic [7:0] ohF;

   bin_to_oh_seq dutA (
      .clk(clk), .rst(rstA), .in_valid(validA), .in_ready(readyA), .in_bin(binA),
      .oh(ohA), .busy(busyA), .done(doneA), .err(errA)
   );

   bin_to_oh_seq #(.WIDTH_OUT(6), .WIDTH_IN(3)) dutR (
      .clk(clk), .rst(rstR), .in_valid(validR), .in_ready(readyR), .in_bin(binR),
      .oh(ohR), .busy(busyR), .done(doneR), .err(errR)
   );

   bin_to_oh_seq #(.GUARD_CYCLES(1), .DWELL_CYCLES(1)) dutF (
      .clk(clk), .rst(rstF), .in_valid(validF), .in_ready(readyF), .in_bin(binF),
      .oh(ohF), .busy(busyF), .done(doneF), .err(errF)
   );

   typedef struct {
      logic [7:0] oh;
      int         busyCycles;
      int         zeroCycles;
   } expT;

   expT expQ[$];
   expT front;
   int  busyCnt = 0;
   int  zeroCnt = 0;
   bit  fActive = 1'b0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic applyStimulus(input logic [2:0] idx, input logic [7:0] expOh, input int expBusy,
                                input int expZero, input bit pushExp, input bit holdValid);
      int  n = 0;
      expT e;
      validA = 1'b1;
      binA   = idx;
      while (readyA !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (readyA !== 1'b1) begin
         checkCount++;
         $display("[TB] FAIL accept_timeout: in_ready=%b, expected 1", readyA);
      end
      if (pushExp) begin
         e.oh         = expOh;
         e.busyCycles = expBusy;
         e.zeroCycles = expZero;
         expQ.push_back(e);
      end
      @(negedge clk);
      if (!holdValid) validA = 1'b0;
   endtask

   task automatic waitDrain();
      int n = 0;
      while (expQ.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("scoreboard_drained", 64'(expQ.size()), 64'(0));
   endtask

   // Monitor: accumulate guard/dwell profile and score it when done pulses.
   always @(negedge clk) begin
      if (rstA) begin
         busyCnt = 0;
         zeroCnt = 0;
      end else begin
         if (busyA) begin
            busyCnt++;
            if (ohA == '0) zeroCnt++;
         end
         if (doneA) begin
            if (expQ.size() == 0) begin
               checkCount++;
               $display("[TB] FAIL unexpected_done: got done=1, expected no pending select");
            end else begin
               front = expQ.pop_front();
               checkOutput("done_oh", 64'(ohA), 64'(front.oh));
               checkOutput("busy_cycles", 64'(busyCnt), 64'(front.busyCycles));
               checkOutput("guard_zero_cycles", 64'(zeroCnt), 64'(front.zeroCycles));
               checkOutput("ready_on_done", 64'(readyA), 64'(1));
               checkOutput("err_on_done", 64'(errA), 64'(0));
            end
            busyCnt = 0;
            zeroCnt = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (fActive) begin
         checkOutput("F_popcount_gt1", 64'($countones(ohF) > 1), 64'(0));
         checkOutput("F_busy_vs_ready", 64'(busyF), 64'(!readyF));
         checkOutput("F_err_low", 64'(errF), 64'(0));
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time expired, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      int errPulses, busyCycles, donePulses, ohNonZero;
      int readyCount, doneCount, countdown;
      logic [7:0] expF;

      rstA = 1'b1; rstR = 1'b1; rstF = 1'b1;
      validA = 1'b0; validR = 1'b0; validF = 1'b0;
      binA = '0; binR = '0; binF = '0;
      repeat (3) @(negedge clk);

      checkOutput("rst_oh", 64'(ohA), 64'(0));
      checkOutput("rst_ready", 64'(readyA), 64'(0));
      checkOutput("rst_busy", 64'(busyA), 64'(0));
      checkOutput("rst_done", 64'(doneA), 64'(0));
      checkOutput("rst_err", 64'(errA), 64'(0));

      #2 rstA = 1'b0; rstR = 1'b0; rstF = 1'b0;
      @(negedge clk);
      checkOutput("release_ready", 64'(readyA), 64'(1));
      checkOutput("release_oh", 64'(ohA), 64'(0));

      // Basic select of index 5
      applyStimulus(3'd5, 8'h20, 18, 2, 1'b1, 1'b0);
      waitDrain();
      repeat (3) @(negedge clk);
      checkOutput("idle_hold_oh", 64'(ohA), 64'h20);
      checkOutput("idle_busy", 64'(busyA), 64'(0));
      checkOutput("idle_ready", 64'(readyA), 64'(1));

      // Back-to-back: 6 waits for the first ready cycle, which is the done cycle of 3
      applyStimulus(3'd3, 8'h08, 18, 2, 1'b1, 1'b1);
      binA = 3'd6;
      n = 0;
      while (readyA !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("b2b_accept_on_done", 64'(doneA), 64'(1));
      front.oh = 8'h40; front.busyCycles = 18; front.zeroCycles = 2;
      expQ.push_back(front);
      @(negedge clk);
      validA = 1'b0;
      waitDrain();
      checkOutput("b2b_final_oh", 64'(ohA), 64'h40);

      // Same index still runs the full guard + dwell
      applyStimulus(3'd6, 8'h40, 18, 2, 1'b1, 1'b0);
      waitDrain();
      applyStimulus(3'd0, 8'h01, 18, 2, 1'b1, 1'b0);
      waitDrain();
      applyStimulus(3'd7, 8'h80, 18, 2, 1'b1, 1'b0);
      waitDrain();

      // Reset on dwell cycle 8
      applyStimulus(3'd2, 8'h00, 0, 0, 1'b0, 1'b0);
      repeat (9) @(negedge clk);
      checkOutput("mid_dwell_oh", 64'(ohA), 64'h04);
      #2 rstA = 1'b1;
      #1;
      checkOutput("mid_rst_oh", 64'(ohA), 64'(0));
      checkOutput("mid_rst_busy", 64'(busyA), 64'(0));
      checkOutput("mid_rst_ready", 64'(readyA), 64'(0));
      @(negedge clk);
      #2 rstA = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_ready", 64'(readyA), 64'(1));
      checkOutput("post_rst_done", 64'(doneA), 64'(0));
      repeat (20) @(negedge clk);
      checkOutput("post_rst_oh", 64'(ohA), 64'(0));
      checkOutput("post_rst_busy", 64'(busyA), 64'(0));
      checkOutput("post_rst_queue", 64'(expQ.size()), 64'(0));

      // Range instance: give oh a known value, then offer index 7
      checkOutput("R_ready", 64'(readyR), 64'(1));
      validR = 1'b1; binR = 3'd2;
      @(negedge clk);
      validR = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("R_oh_after_select", 64'(ohR), 64'h04);
      validR = 1'b1; binR = 3'd7;
      @(negedge clk);
      validR = 1'b0;
      errPulses = 0; busyCycles = 0; donePulses = 0; ohNonZero = 0;
      for (int k = 0; k < 30; k++) begin
         if (errR) errPulses++;
         if (busyR) busyCycles++;
         if (doneR) donePulses++;
         if (busyR && ohR != '0) ohNonZero++;
         @(negedge clk);
      end
`ifdef BIN_TO_OH_RANGE_CHECK_EN
      checkOutput("R_err_pulses", 64'(errPulses), 64'(1));
      checkOutput("R_busy_cycles", 64'(busyCycles), 64'(0));
      checkOutput("R_done_pulses", 64'(donePulses), 64'(0));
      checkOutput("R_oh_unchanged", 64'(ohR), 64'h04);
`else
      checkOutput("R_err_pulses", 64'(errPulses), 64'(0));
      checkOutput("R_busy_cycles", 64'(busyCycles), 64'(18));
      checkOutput("R_done_pulses", 64'(donePulses), 64'(1));
      checkOutput("R_oh_nonzero_busy", 64'(ohNonZero), 64'(0));
      checkOutput("R_oh_final", 64'(ohR), 64'(0));
`endif

      // Minimal timing instance: random indices with in_valid held high
      fActive = 1'b1;
      readyCount = 0; doneCount = 0; countdown = 0; expF = '0;
      validF = 1'b1;
      binF = 3'($urandom_range(0, 7));
      for (int k = 0; k < 30; k++) begin
         if (countdown == 2) checkOutput("F_guard_zero", 64'(ohF), 64'(0));
         if (countdown == 1) checkOutput("F_dwell_oh", 64'(ohF), 64'(expF));
         if (countdown > 0) countdown--;
         if (doneF) doneCount++;
         if (readyF) begin
            readyCount++;
            expF = 8'(1) << binF;
            countdown = 2;
         end
         @(negedge clk);
         binF = 3'($urandom_range(0, 7));
      end
      validF = 1'b0;
      fActive = 1'b0;
      checkOutput("F_ready_duty", 64'(readyCount), 64'(10));
      checkOutput("F_done_count", 64'(doneCount), 64'(9));

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
